// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package mem_responder_pkg;

   // Bus direction encoding carried on mem_rw.
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   // Bus widths of the mem_ctrl access bus.
   localparam int WORD_ADDR_BUS  = 30;
   localparam int DATA_WIDTH_GPR = 32;
   localparam int BYTE_EN_W      = 4;

   // Responder FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_sram_be.sv
// Single-port synchronous RAM with per-byte write mask and a registered,
// clearable read-data output that holds its value between reads.
module mem_sram_be
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [BYTE_EN_W-1:0]      wr_be,
   input  logic                      rd_en,
   input  logic                      rd_zero,
   input  logic [IDX_W-1:0]          addr,
   input  logic [DATA_WIDTH_GPR-1:0] wr_data,
   output logic [DATA_WIDTH_GPR-1:0] rd_data
);

   logic [DATA_WIDTH_GPR-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_WIDTH_GPR-1:0] rd_data_q;
   logic [DATA_WIDTH_GPR-1:0] rd_data_d;

   // Array storage: only enabled byte lanes are written; the array is never reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < BYTE_EN_W; k++) begin
         if (wr_en && wr_be[k]) begin
            mem_q[addr][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   // Next read data: hold unless a read is performed; an out-of-range read returns zero.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = rd_zero ? '0 : mem_q[addr];
      end
   end

   // Read-data register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Target end of the mem_ctrl access bus: captures a strobed request, waits
// WAIT_CYCLES, performs the access and answers with a one-cycle mem_rdy pulse.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_as_,
   input  logic                      mem_rw,
   input  logic [WORD_ADDR_BUS-1:0]  mem_addr,
   input  logic [DATA_WIDTH_GPR-1:0] mem_wr_data,
   input  logic [BYTE_EN_W-1:0]      mem_byte_en,
   output logic [DATA_WIDTH_GPR-1:0] mem_rd_data,
   output logic                      mem_rdy,
   output logic                      mem_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e                    state_q, state_d;
   logic [3:0]                wait_cnt_q, wait_cnt_d;
   logic                      rw_q, rw_d;
   logic [WORD_ADDR_BUS-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH_GPR-1:0] wdata_q, wdata_d;
   logic [BYTE_EN_W-1:0]      be_q, be_d;
   logic                      rdy_q, rdy_d;
   logic                      err_q, err_d;

   logic                      capture;
   logic                      in_range;
   logic                      sram_we;
   logic                      sram_re;
   logic                      sram_zero;

   // Unsigned compare of the full captured word address against the array depth.
   assign in_range = ({2'b00, addr_q} < 32'(DEPTH_WORDS));

   // Next-state, capture and access control; a low strobe in IDLE or RESP starts a request.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rdy_d      = 1'b0;
      err_d      = 1'b0;
      capture    = 1'b0;
      sram_we    = 1'b0;
      sram_re    = 1'b0;
      sram_zero  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!mem_as_) begin
               capture = 1'b1;
            end
         end
         ST_BUSY: begin
            if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else begin
               rdy_d   = 1'b1;
               err_d   = !in_range;
               state_d = ST_RESP;
               if (rw_q == READ) begin
                  sram_re   = 1'b1;
                  sram_zero = !in_range;
               end else begin
                  sram_we = in_range;
               end
            end
         end
         ST_RESP: begin
            if (!mem_as_) begin
               capture = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (capture) begin
         rw_d       = mem_rw;
         addr_d     = mem_addr;
         wdata_d    = mem_wr_data;
         be_d       = mem_byte_en;
         wait_cnt_d = 4'(WAIT_CYCLES);
         state_d    = ST_BUSY;
      end
   end

   // State, request copy, wait counter and response flags; reset aborts any request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
      end
   end

   mem_sram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_sram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (sram_we),
      .wr_be   (be_q),
      .rd_en   (sram_re),
      .rd_zero (sram_zero),
      .addr    (addr_q[IDX_W-1:0]),
      .wr_data (wdata_q),
      .rd_data (mem_rd_data)
   );

   assign mem_rdy = rdy_q;
   assign mem_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 has WAIT_CYCLES=2 and
// DEPTH_WORDS=1000, instance 1 has WAIT_CYCLES=0 and the default depth.
module tb_mem_responder;

   localparam int W0 = 2;
   localparam int W1 = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        as_n    [2];
   logic        rw      [2];
   logic [29:0] addr    [2];
   logic [31:0] wdata   [2];
   logic [3:0]  be      [2];
   logic [31:0] rd_data [2];
   logic        rdy     [2];
   logic        err     [2];

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   issued   [2];
   int   resp_cnt [2];

   always #5 clk = ~clk;

   // Edge counter: after rising edge M, cyc reads M.
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DEPTH_WORDS(1000), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst(rst), .mem_as_(as_n[0]), .mem_rw(rw[0]), .mem_addr(addr[0]),
      .mem_wr_data(wdata[0]), .mem_byte_en(be[0]), .mem_rd_data(rd_data[0]),
      .mem_rdy(rdy[0]), .mem_err(err[0])
   );

   mem_responder #(.WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst(rst), .mem_as_(as_n[1]), .mem_rw(rw[1]), .mem_addr(addr[1]),
      .mem_wr_data(wdata[1]), .mem_byte_en(be[1]), .mem_rd_data(rd_data[1]),
      .mem_rdy(rdy[1]), .mem_err(err[1])
   );

   // Single comparison with counting and a FAIL line on mismatch.
   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Monitor-side check of one mem_rdy pulse against the oldest expected response.
   task automatic checkOutput(input int i);
      exp_t e;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL inst%0d unexpected mem_rdy at edge %0d", i, cyc);
      end else begin
         if (i == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         check_val($sformatf("inst%0d rdy edge", i), cyc, e.cyc);
         check_val($sformatf("inst%0d mem_err", i), {31'd0, err[i]}, {31'd0, e.err});
         check_val($sformatf("inst%0d mem_rd_data", i), rd_data[i], e.data);
      end
      resp_cnt[i]++;
   endtask

   always @(negedge clk) if (!rst && rdy[0]) checkOutput(0);
   always @(negedge clk) if (!rst && rdy[1]) checkOutput(1);

   // Record the expected response for a request captured at the current edge.
   task automatic push_exp(input int i, input logic [31:0] d, input logic e);
      exp_t x;
      x.data = d;
      x.err  = e;
      x.cyc  = cyc + 1 + ((i == 0) ? W0 : W1);
      if (i == 0) q0.push_back(x);
      else        q1.push_back(x);
      issued[i]++;
   endtask

   // Bounded wait until every issued request on instance i has responded.
   task automatic wait_done(input int i);
      for (int k = 0; k < 60; k++) begin
         if (resp_cnt[i] >= issued[i]) break;
         @(negedge clk);
         #2;
      end
      check_val($sformatf("inst%0d responses", i), resp_cnt[i], issued[i]);
   endtask

   // Issue one request, release the strobe after capture and wait for completion.
   task automatic applyStimulus(input int i, input logic r, input logic [29:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input logic [31:0] exp_d, input logic exp_e);
      @(negedge clk);
      rw[i] = r; addr[i] = a; wdata[i] = d; be[i] = b; as_n[i] = 1'b0;
      @(posedge clk);
      #1;
      as_n[i] = 1'b1;
      push_exp(i, exp_d, exp_e);
      wait_done(i);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         as_n[i] = 1'b1; rw[i] = 1'b1; addr[i] = '0; wdata[i] = '0; be[i] = '0;
         issued[i] = 0; resp_cnt[i] = 0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("inst%0d reset rd_data", i), rd_data[i], 32'h0);
         check_val($sformatf("inst%0d reset rdy", i), {31'd0, rdy[i]}, 32'h0);
         check_val($sformatf("inst%0d reset err", i), {31'd0, err[i]}, 32'h0);
      end
      rst = 1'b0;

      // Instance 0: full write, read back, byte-lane merge.
      applyStimulus(0, 1'b0, 30'd5, 32'h01234567, 4'b1111, 32'h00000000, 1'b0);
      applyStimulus(0, 1'b1, 30'd5, 32'h0,        4'b0000, 32'h01234567, 1'b0);
      applyStimulus(0, 1'b0, 30'd5, 32'hAABBCCDD, 4'b0101, 32'h01234567, 1'b0);
      applyStimulus(0, 1'b1, 30'd5, 32'h0,        4'b1111, 32'h01BB45DD, 1'b0);
      applyStimulus(0, 1'b0, 30'd6, 32'h11111111, 4'b1111, 32'h01BB45DD, 1'b0);

      // Back-to-back reads of addr 5 then addr 6 with the strobe held low.
      @(negedge clk);
      rw[0] = 1'b1; addr[0] = 30'd5; be[0] = 4'b0000; as_n[0] = 1'b0;
      @(posedge clk);
      #1;
      push_exp(0, 32'h01BB45DD, 1'b0);
      addr[0] = 30'd6;
      repeat (4) @(posedge clk);
      #1;
      push_exp(0, 32'h11111111, 1'b0);
      as_n[0] = 1'b1;
      wait_done(0);

      // Range checks against depth 1000, including an aliasing address.
      applyStimulus(0, 1'b0, 30'd0,    32'hCAFEF00D, 4'b1111, 32'h11111111, 1'b0);
      applyStimulus(0, 1'b0, 30'd999,  32'h5A5A5A5A, 4'b1111, 32'h11111111, 1'b0);
      applyStimulus(0, 1'b0, 30'd1000, 32'hDEADBEEF, 4'b1111, 32'h11111111, 1'b1);
      applyStimulus(0, 1'b0, 30'd1024, 32'hDEADBEEF, 4'b1111, 32'h11111111, 1'b1);
      applyStimulus(0, 1'b1, 30'd0,    32'h0,        4'b0000, 32'hCAFEF00D, 1'b0);
      applyStimulus(0, 1'b1, 30'd999,  32'h0,        4'b0000, 32'h5A5A5A5A, 1'b0);
      applyStimulus(0, 1'b1, 30'h3FFFFFFF, 32'h0,    4'b0000, 32'h00000000, 1'b1);

      // Reset one cycle after capturing a write to addr 7.
      applyStimulus(0, 1'b0, 30'd7, 32'h12345678, 4'b1111, 32'h00000000, 1'b0);
      applyStimulus(0, 1'b1, 30'd7, 32'h0,        4'b0000, 32'h12345678, 1'b0);
      @(negedge clk);
      rw[0] = 1'b0; addr[0] = 30'd7; wdata[0] = 32'hFFFFFFFF; be[0] = 4'b1111; as_n[0] = 1'b0;
      @(posedge clk);
      #1;
      as_n[0] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("async reset rd_data", rd_data[0], 32'h0);
      check_val("async reset rdy", {31'd0, rdy[0]}, 32'h0);
      check_val("async reset err", {31'd0, err[0]}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      applyStimulus(0, 1'b1, 30'd7, 32'h0, 4'b0000, 32'h12345678, 1'b0);

      // Instance 1: zero wait states, zero byte-enable write, out of range at 1024.
      applyStimulus(1, 1'b0, 30'd3,    32'h89ABCDEF, 4'b1111, 32'h00000000, 1'b0);
      applyStimulus(1, 1'b1, 30'd3,    32'h0,        4'b0000, 32'h89ABCDEF, 1'b0);
      applyStimulus(1, 1'b0, 30'd3,    32'h00000000, 4'b0000, 32'h89ABCDEF, 1'b0);
      applyStimulus(1, 1'b1, 30'd3,    32'h0,        4'b1111, 32'h89ABCDEF, 1'b0);
      applyStimulus(1, 1'b1, 30'd1024, 32'h0,        4'b0000, 32'h00000000, 1'b1);

      repeat (5) @(negedge clk);
      check_val("inst0 leftover expectations", q0.size(), 32'd0);
      check_val("inst1 leftover expectations", q1.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data-memory responder: the target end of the `mem_ctrl` access bus. It accepts requests strobed by `mem_as_`, inserts a parameterised number of wait states, and performs a byte-enabled write or a full-word read on an internal SRAM array. It completes every request with a one-cycle `mem_rdy` pulse and an error flag for out-of-range addresses. It sits between `mem_ctrl` in the MEM stage and the on-chip data RAM.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array; need not be a power of 2.
- `WAIT_CYCLES`, default 2: wait states inserted before the access; 0 is legal; maximum 15.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_as_`  in  1  address strobe, active low; a low sample is a request.
- `mem_rw`  in  1  `READ` (1) or `WRITE` (0), from `define.v`.
- `mem_addr`  in  `WORD_ADDR_BUS` (30)  word address.
- `mem_wr_data`  in  `DATA_WIDTH_GPR` (32)  write data.
- `mem_byte_en`  in  4  byte-lane enables; bit k gates bits [8k+7:8k]; ignored on reads.
- `mem_rd_data`  out  32  registered read data.
- `mem_rdy`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  out-of-range flag; valid only while `mem_rdy` is high.

## Operation
- FSM states: IDLE, BUSY, RESP; encodings are in `define.v`.
- IDLE: when `mem_as_`=0 at an edge, register `mem_rw`, `mem_addr`, `mem_wr_data` and `mem_byte_en`, load `wait_cnt`=`WAIT_CYCLES`, and go to BUSY.
- BUSY, `wait_cnt`!=0: decrement `wait_cnt`. Bus inputs are ignored; the access uses only the captured copy.
- BUSY, `wait_cnt`==0: perform the access, set `mem_rdy`=1, and go to RESP.
  - Write, in range: update only the enabled bytes and preserve the others. `mem_rd_data` is unchanged.
  - Read, in range: `mem_rd_data` = array[addr].
  - Out of range (addr >= `DEPTH_WORDS`): no array access, `mem_err`=1; on a read, `mem_rd_data`=0.
- RESP, lasting 1 cycle: at the next edge `mem_rdy`=0 and `mem_err`=0.
  - If `mem_as_`=0 at that edge, capture a new request directly and go to BUSY (back-to-back).
  - Otherwise go to IDLE.
- The initiator must deassert `mem_as_` in the RESP cycle if it has no further request. A strobe still low there is treated as a new request.
- A write with `mem_byte_en`=0000 still completes with `mem_rdy`; the array is unchanged.
- `mem_rd_data` holds the last read result until the next read completes; writes do not disturb it.

## Timing
- Reset values: state=IDLE, `mem_rdy`=0, `mem_err`=0, `mem_rd_data`=0, `wait_cnt`=0. The array is not cleared.
- Reset asserted mid-request aborts it immediately: no `mem_rdy`, and a pending write is discarded (array untouched).
- Latency: with the request captured at edge N, `mem_rdy` is high during the cycle after edge N+1+`WAIT_CYCLES`.
  - `WAIT_CYCLES`=0: `mem_rdy` high after edge N+1.
  - `WAIT_CYCLES`=2: `mem_rdy` high after edge N+3.
- Throughput: one request per `WAIT_CYCLES`+2 cycles with a continuously low strobe.
- Array read is synchronous. The write and the read-data register update on the same edge that raises `mem_rdy`.
- Address compare is a 30-bit unsigned compare against `DEPTH_WORDS`. Only the low $clog2(`DEPTH_WORDS`) bits index the array.

## Structure
- `define.v` supplies: `READ`/`WRITE`, `WORD_ADDR_BUS`, `DATA_WIDTH_GPR`, the FSM state encodings, and a `BYTE_EN_W`=4 constant.
- Sub-module `mem_sram_be`: a single-port synchronous RAM with a per-byte write mask, parameterised by depth.
- `mem_responder` itself holds the FSM, the request capture registers, the wait counter and the range check.

## Test plan
- Reset, `WAIT_CYCLES`=2: write 0x01234567, be=1111, to addr 5 (captured edge N); `mem_rdy` pulses one cycle after edge N+3. Reading addr 5 then returns 0x01234567 with `mem_err`=0.
- Byte lanes: after the word above, write 0xAABBCCDD with be=0101 to addr 5; a read returns 0x01BB45DD.
- Back-to-back: hold `mem_as_` low for read addr 5 then read addr 6 (addr 6 preloaded with 0x11111111). Two `mem_rdy` pulses 4 cycles apart, `mem_rd_data` 0x01BB45DD then 0x11111111.
- Range, `DEPTH_WORDS`=1000: write to addr 1000 leaves addr 0 (0xCAFEF00D) unchanged with `mem_err`=1 on `mem_rdy`. A read of addr 0x3FFFFFFF returns 0 with `mem_err`=1.
- Reset mid-operation: assert `rst` one cycle after capturing a write of 0xFFFFFFFF to addr 7 (previously 0x12345678). There is no `mem_rdy`, outputs go to 0 asynchronously, and a later read of addr 7 returns 0x12345678.
- `WAIT_CYCLES`=0: a read captured at edge N gives `mem_rdy` after edge N+1. A zero-byte-enable write completes with `mem_rdy` and changes nothing.
